button_debounce_conditioner: RTL and testbench

Conditions the raw DE1-SoC push-button pin before it reaches the `bridge` system's `button_external_export` PIO input. Performs the following, in order:
- 2-FF synchronization
- polarity normalization
- counter-based debounce FSM
- press/release event pulse generation and a press event counter for fabric-side logic

Its `btn_level_out` drives `button_external_export` directly, so HPS software sees a clean, active-high level.

---
 rtl/button_debounce_conditioner_if.sv | 33 +++
 rtl/button_debounce_conditioner.sv | 188 ++++++++++++++++++
 tb/tb_button_debounce_conditioner.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_conditioner_if.sv
// Button conditioner signal bundle: raw pin and count clear in, conditioned level and events out.
// slave = conditioner side, master = consumer/driver side.
interface button_debounce_conditioner_if #(
    parameter int CNT_W = 16
);
    logic             btn_raw_in;
    logic             clear_count;
    logic             btn_level_out;
    logic             press_pulse;
    logic             release_pulse;
    logic             long_press_pulse;
    logic [CNT_W-1:0] press_count;

    modport master (
        output btn_raw_in,
        output clear_count,
        input  btn_level_out,
        input  press_pulse,
        input  release_pulse,
        input  long_press_pulse,
        input  press_count
    );

    modport slave (
        input  btn_raw_in,
        input  clear_count,
        output btn_level_out,
        output press_pulse,
        output release_pulse,
        output long_press_pulse,
        output press_count
    );
endinterface

// File: rtl/button_debounce_conditioner.sv
// Push-button conditioner: 2-FF sync, polarity fix, debounce FSM, press/release pulses, press counter.
// Latency: raw sampled at edge N -> level/pulse at edge N+2+DEBOUNCE_CYCLES; no backpressure, pulses are fire-and-forget.
// Optional long-press event when BUTTON_LONG_PRESS_EN is defined; otherwise long_press_pulse is tied low.
module button_debounce_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b1,
    parameter int CNT_W             = 16
) (
    input  logic                                clk_clk,
    input  logic                                reset_reset_n,
    button_debounce_conditioner_if.slave        btn
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_lp
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    // Third flop holds the normalised sample so the FSM sees 's' two edges after first capture.
    logic sync1_q, sync2_q, s_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= BTN_ACTIVE_LOW;
            sync2_q <= BTN_ACTIVE_LOW;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= btn.btn_raw_in;
            sync2_q <= sync1_q;
            s_q     <= sync2_q ^ BTN_ACTIVE_LOW;
        end
    end

    state_t           state_q, state_d;
    logic [DB_W-1:0]  dbc_q, dbc_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            dbc_q   <= '0;
        end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;
        case (state_q)
            ST_IDLE: begin
                if (s_q) begin
                    state_d = ST_PRESS_WAIT;
                    dbc_d   = DB_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s_q) begin
                    state_d = ST_IDLE;
                    dbc_d   = '0;
                end else if (dbc_q == DB_LAST) begin
                    state_d = ST_PRESSED;
                    dbc_d   = '0;
                end else if (dbc_q != DB_MAX) begin
                    dbc_d = dbc_q + DB_ONE;
                end
            end
            ST_PRESSED: begin
                if (!s_q) begin
                    state_d = ST_RELEASE_WAIT;
                    dbc_d   = DB_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s_q) begin
                    state_d = ST_PRESSED;
                    dbc_d   = '0;
                end else if (dbc_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    dbc_d   = '0;
                end else if (dbc_q != DB_MAX) begin
                    dbc_d = dbc_q + DB_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dbc_d   = '0;
            end
        endcase
    end

    logic level_d, press_d, release_d;

    always_comb begin
        level_d   = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
        press_d   = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);
        release_d = (state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE);
    end

    // A clear coinciding with an accepted press leaves the count at one.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (press_d) begin
            cnt_d = btn.clear_count ? CNT_ONE : cnt_q + CNT_ONE;
        end else if (btn.clear_count) begin
            cnt_d = '0;
        end
    end

    logic level_q, press_q, release_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign btn.btn_level_out = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.press_count   = cnt_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);

    logic [LP_W-1:0] lpt_q, lpt_d;
    logic            long_q, long_d;

    // Timer parks at LONG_PRESS_CYCLES so the event fires at most once per press.
    always_comb begin
        lpt_d  = lpt_q;
        long_d = 1'b0;
        if ((state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT)) begin
            long_d = (lpt_q == LP_LAST);
            if (lpt_q != LP_MAX) begin
                lpt_d = lpt_q + LP_ONE;
            end
        end
        if (press_d || (state_d == ST_IDLE)) begin
            lpt_d = '0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lpt_q  <= '0;
            long_q <= 1'b0;
        end else begin
            lpt_q  <= lpt_d;
            long_q <= long_d;
        end
    end

    assign btn.long_press_pulse = long_q;
`else
    assign btn.long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_conditioner.sv
// Randomised and directed bench for button_debounce_conditioner against a run-length reference model.
module tb_button_debounce_conditioner;
    localparam int DEB  = 8;
    localparam int LONG = 32;
    localparam int CW   = 4;
    localparam int LAT  = 1 + 2 + DEB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_debounce_conditioner_if #(.CNT_W(CW)) bus ();

    button_debounce_conditioner #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .BTN_ACTIVE_LOW   (1'b1),
        .CNT_W            (CW)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .btn          (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the accepted level flips once 's' has disagreed with it for DEB consecutive edges.
    bit dly [3];
    bit m_lvl;
    int m_run;
    int m_cnt;
    int m_since;
    bit m_armed;
    bit m_press, m_release, m_long;

    int ev_press, ev_release, ev_long;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) dly[i] = 1'b0;
        m_lvl = 0; m_run = 0; m_cnt = 0; m_since = 0; m_armed = 0;
        m_press = 0; m_release = 0; m_long = 0;
    endtask

    task automatic model_edge(input bit raw, input bit clr);
        bit s_seen;
        bit prev_lvl;
        s_seen   = dly[2];
        prev_lvl = m_lvl;
        m_press = 0; m_release = 0; m_long = 0;
        dly[2] = dly[1];
        dly[1] = dly[0];
        dly[0] = !raw;
        if (s_seen != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
                m_lvl = s_seen;
                m_run = 0;
                if (m_lvl) m_press = 1; else m_release = 1;
            end
        end else begin
            m_run = 0;
        end
        if (prev_lvl) begin
            m_since++;
            if (m_armed && m_since == LONG) begin
                m_long  = 1;
                m_armed = 0;
            end
        end
        if (m_press) begin
            m_since = 0;
            m_armed = 1;
            m_cnt   = clr ? 1 : (m_cnt + 1) % (1 << CW);
        end else if (clr) begin
            m_cnt = 0;
        end
    endtask

    function automatic bit exp_long();
`ifdef BUTTON_LONG_PRESS_EN
        return m_long;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: drive at negedge, update model at posedge, compare at the following negedge.
    task automatic cycle(input bit raw, input bit clr);
        bus.btn_raw_in  = raw;
        bus.clear_count = clr;
        @(posedge clk);
        model_edge(raw, clr);
        @(negedge clk);
        check("level",   bus.btn_level_out,    m_lvl);
        check("press",   bus.press_pulse,      m_press);
        check("release", bus.release_pulse,    m_release);
        check("long",    bus.long_press_pulse, exp_long());
        check("count",   bus.press_count,      m_cnt);
        check("pulse_excl", bus.press_pulse & bus.release_pulse, 0);
        if (bus.press_pulse)      ev_press++;
        if (bus.release_pulse)    ev_release++;
        if (bus.long_press_pulse) ev_long++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"},   bus.btn_level_out,    0);
        check({tag, "_press"},   bus.press_pulse,      0);
        check({tag, "_release"}, bus.release_pulse,    0);
        check({tag, "_long"},    bus.long_press_pulse, 0);
        check({tag, "_count"},   bus.press_count,      0);
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible before the next edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_press(input bit clr_on_accept, output int lat);
        lat = -1;
        for (int i = 1; i <= 3 * LAT; i++) begin
            cycle(1'b0, clr_on_accept && (i == LAT));
            if (bus.press_pulse) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_release(output int lat);
        lat = -1;
        for (int i = 1; i <= 3 * LAT; i++) begin
            cycle(1'b1, 1'b0);
            if (bus.release_pulse) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int p0, r0, l0;
        bit r;
        int len;

        bus.btn_raw_in  = 1'b1;
        bus.clear_count = 1'b0;
        model_reset();
        ev_press = 0; ev_release = 0; ev_long = 0;
        #3 check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 1'b0);

        // Clean press and release
        wait_press(1'b0, lat);
        check("press_latency", lat, LAT);
        check("press_count_first", bus.press_count, 1);
        repeat (4) cycle(1'b0, 1'b0);
        wait_release(lat);
        check("release_latency", lat, LAT);
        repeat (4) cycle(1'b1, 1'b0);

        // Press bounce shorter than the debounce window
        p0 = ev_press;
        repeat (5) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0);
        check("bounce_no_press", ev_press - p0, 0);
        check("bounce_level", bus.btn_level_out, 0);

        // Release bounce
        wait_press(1'b0, lat);
        repeat (5) cycle(1'b0, 1'b0);
        p0 = ev_press; r0 = ev_release;
        repeat (4) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        check("rel_bounce_level_held", bus.btn_level_out, 1);
        wait_release(lat);
        check("rel_bounce_latency", lat, LAT);
        repeat (10) cycle(1'b1, 1'b0);
        check("rel_bounce_one_release", ev_release - r0, 1);
        check("rel_bounce_no_press", ev_press - p0, 0);

        // Long press
        wait_press(1'b0, lat);
        l0 = ev_long;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            cycle(1'b0, 1'b0);
            if (bus.long_press_pulse && lat < 0) lat = i;
        end
`ifdef BUTTON_LONG_PRESS_EN
        check("long_count", ev_long - l0, 1);
        check("long_offset", lat, LONG);
`else
        check("long_count", ev_long - l0, 0);
`endif
        wait_release(lat);
        repeat (4) cycle(1'b1, 1'b0);

        // Counter wrap and clear interaction
        do_reset("rst_wrap");
        repeat (17) begin
            wait_press(1'b0, lat);
            repeat (2) cycle(1'b0, 1'b0);
            wait_release(lat);
            repeat (2) cycle(1'b1, 1'b0);
        end
        check("wrap_count", bus.press_count, 1);
        wait_press(1'b1, lat);
        check("clear_press_latency", lat, LAT);
        check("clear_with_press", bus.press_count, 1);
        cycle(1'b0, 1'b1);
        check("clear_alone", bus.press_count, 0);
        check("clear_fsm_level", bus.btn_level_out, 1);

        // Reset while pressed, raw held low throughout
        do_reset("rst_mid");
        wait_press(1'b0, lat);
        check("rst_mid_latency", lat, LAT);
        check("rst_mid_count", bus.press_count, 1);
        repeat (4) cycle(1'b0, 1'b0);
        wait_release(lat);

        // Random segments with occasional clears
        for (int seg = 0; seg < 300; seg++) begin
            r   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) cycle(r, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
